// File: rtl/led_shift_sched_pkg.sv
// -----------------------------------------------------------------------------
// led_shift_sched_pkg
// Shared types and constants for the LED shift-chain sequencer.
//   state_e       : frame sequencer states
//   LED_FRAME_W   : bits per serial frame on the board chain
//   CLR_HALVES    : led_clk half periods spent in the clear phase
//   LATCH_HALVES  : led_clk half periods spent in the latch phase
//   rr_pick()     : two-way round-robin winner selection
// -----------------------------------------------------------------------------
package led_shift_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        LATCH = 2'd3
    } state_e;

    localparam int LED_FRAME_W  = 16;
    localparam int CLR_HALVES   = 2;
    localparam int LATCH_HALVES = 2;

    // On a tie the requester that did not own the last frame wins;
    // otherwise the only active requester wins.
    function automatic logic rr_pick(input logic [1:0] req, input logic last_owner);
        if (req == 2'b11) begin
            return ~last_owner;
        end
        return req[1];
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// -----------------------------------------------------------------------------
// led_tick_gen
// Half-period divider for the LED shift clock. Counts DIV system cycles while
// enabled and flags the last one; the count restarts on clr_i (state entry).
// Ports:
//   clk     in  system clock
//   rst     in  asynchronous active-high reset
//   en_i    in  synchronous count enable (count held at 0 when low)
//   clr_i   in  synchronous count restart
//   tick_o  out high on the final cycle of each DIV-cycle half period
// -----------------------------------------------------------------------------
module led_tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    // A one-cycle divider still needs a 1-bit counter to stay legal.
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || clr_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, matching real hardware ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_shift_sched.sv
// -----------------------------------------------------------------------------
// led_shift_sched
// Round-robin arbiter and frame sequencer for the serial 16-LED shift chain.
// A granted requester's pattern is captured and sent as: clear pulse, WIDTH
// bits MSB first (data valid on led_clk rising edge), latch pulse.
// Optional build macro: LED_SHIFT_INV_EN -- invert the captured pattern for
// active-low LEDs (timing and reset levels unchanged).
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   req[1:0]          request levels, held until acked
//   data0, data1      patterns, captured at grant
//   ack[1:0]          one-hot accept pulse
//   done              pulse on the last latch cycle
//   busy              high from ack through done inclusive
//   owner             current/last granted requester
//   led_clk, led_clr, led_en, led_d0   registered chain pins
// -----------------------------------------------------------------------------
module led_shift_sched
    import led_shift_sched_pkg::*;
#(
    parameter int DIV   = 2,
    parameter int WIDTH = LED_FRAME_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic [1:0]       ack,
    output logic             done,
    output logic             busy,
    output logic             owner,
    output logic             led_clk,
    output logic             led_clr,
    output logic             led_en,
    output logic             led_d0
);

    localparam int HW = $clog2(2 * WIDTH);

    state_e           state_q, state_d;
    logic [HW-1:0]    half_q, half_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [1:0]       ack_q, ack_d;
    logic             owner_q, owner_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             led_clk_q, led_clk_d;
    logic             led_clr_q, led_clr_d;
    logic             led_en_q, led_en_d;
    logic             led_d0_q, led_d0_d;

    logic             tick;
    logic             phase_last;
    logic             grant;
    logic             win;
    logic [HW-1:0]    last_half;
    logic [WIDTH-1:0] load_pat;

    led_tick_gen #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q != IDLE),
        .clr_i  (state_d != state_q),
        .tick_o (tick)
    );

    // Outputs lag the state by one cycle, so busy_q is still high in the
    // first IDLE cycle after done; blocking the grant there leaves exactly
    // one visible idle cycle between frames.
    assign grant = (state_q == IDLE) && !busy_q && (|req);
    assign win   = rr_pick(req, owner_q);

    always_comb begin
        load_pat = win ? data1 : data0;
`ifdef LED_SHIFT_INV_EN
        load_pat = ~load_pat;
`endif
    end

    always_comb begin
        last_half = '0;
        case (state_q)
            CLEAR:   last_half = HW'(CLR_HALVES - 1);
            SHIFT:   last_half = HW'(2 * WIDTH - 1);
            LATCH:   last_half = HW'(LATCH_HALVES - 1);
            default: last_half = '0;
        endcase
    end

    assign phase_last = tick && (half_q == last_half);

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        half_d    = half_q;
        sr_d      = sr_q;
        ack_d     = 2'b00;
        owner_d   = owner_q;
        led_d0_d  = led_d0_q;

        case (state_q)
            IDLE:    if (grant)      state_d = CLEAR;
            CLEAR:   if (phase_last) state_d = SHIFT;
            SHIFT:   if (phase_last) state_d = LATCH;
            LATCH:   if (phase_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            half_d = '0;
        end else if (tick) begin
            half_d = half_q + 1'b1;
        end

        if (grant) begin
            ack_d   = win ? 2'b10 : 2'b01;
            owner_d = win;
            sr_d    = load_pat;
        end else if (state_q == SHIFT && tick && half_q[0]) begin
            // Advance at the end of the high half so the next bit appears
            // with the following low half.
            sr_d = sr_q << 1;
        end

        if (state_q == SHIFT) begin
            led_d0_d = sr_q[WIDTH-1];
        end

        busy_d    = grant || (state_q != IDLE);
        done_d    = (state_q == LATCH) && phase_last;
        led_clk_d = (state_q == SHIFT) && half_q[0];
        led_clr_d = (state_q != CLEAR);
        led_en_d  = (state_q == LATCH);
    end

    // NOTE: the shift register is reset along with the control flops; it is a
    // single word, and a known value keeps led_d0 defined after any abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            half_q    <= '0;
            sr_q      <= '0;
            ack_q     <= 2'b00;
            owner_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            led_clk_q <= 1'b0;
            led_clr_q <= 1'b1;
            led_en_q  <= 1'b0;
            led_d0_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            half_q    <= half_d;
            sr_q      <= sr_d;
            ack_q     <= ack_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            led_clk_q <= led_clk_d;
            led_clr_q <= led_clr_d;
            led_en_q  <= led_en_d;
            led_d0_q  <= led_d0_d;
        end
    end

    assign ack     = ack_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign owner   = owner_q;
    assign led_clk = led_clk_q;
    assign led_clr = led_clr_q;
    assign led_en  = led_en_q;
    assign led_d0  = led_d0_q;

endmodule

// File: tb/tb_led_shift_sched.sv
// -----------------------------------------------------------------------------
// tb_led_shift_sched
// Bench for led_shift_sched: a DIV=2 instance driven by a vector table plus
// hand-written tie / withdraw / mid-frame reset sequences, and a DIV=1
// instance checked for frame length and shift clock rate. Expected frames are
// queued when a request is driven and checked as the DUT acks and completes.
// -----------------------------------------------------------------------------
module tb_led_shift_sched;

    typedef struct {
        logic [1:0]  ack;
        logic        owner;
        logic [15:0] bits;
    } exp_t;

    typedef struct {
        logic [1:0]  req;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [1:0]  exp_ack;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [1:0]  req = 2'b00;
    logic [15:0] data0 = '0, data1 = '0;
    logic [1:0]  ack;
    logic        done, busy, owner, led_clk, led_clr, led_en, led_d0;

    logic [1:0]  req_b = 2'b00;
    logic [15:0] data0_b = '0, data1_b = '0;
    logic [1:0]  ack_b;
    logic        done_b, busy_b, owner_b, led_clk_b, led_clr_b, led_en_b, led_d0_b;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t sb_q[$];

    int cyc = 0;
    int ack_cnt = 0, done_cnt = 0;
    int last_ack_cyc = 0, prev_ack_cyc = 0;

    always #5 clk = ~clk;

    led_shift_sched #(.DIV(2)) dut (
        .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1),
        .ack(ack), .done(done), .busy(busy), .owner(owner),
        .led_clk(led_clk), .led_clr(led_clr), .led_en(led_en), .led_d0(led_d0)
    );

    led_shift_sched #(.DIV(1)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .data0(data0_b), .data1(data1_b),
        .ack(ack_b), .done(done_b), .busy(busy_b), .owner(owner_b),
        .led_clk(led_clk_b), .led_clr(led_clr_b), .led_en(led_en_b), .led_d0(led_d0_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] shown(input logic [15:0] pat);
`ifdef LED_SHIFT_INV_EN
        return ~pat;
`else
        return pat;
`endif
    endfunction

    function automatic exp_t mk_exp(input logic [1:0] a, input logic [15:0] d0, input logic [15:0] d1);
        exp_t e;
        e.ack   = a;
        e.owner = a[1];
        e.bits  = shown(a[1] ? d1 : d0);
        return e;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_acks(input string name, input int target, input int budget);
        int n = 0;
        while (ack_cnt < target && n < budget) begin
            step();
            n++;
        end
        check(name, 32'(ack_cnt >= target), 32'd1);
    endtask

    task automatic wait_dones(input string name, input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            step();
            n++;
        end
        check(name, 32'(done_cnt >= target), 32'd1);
    endtask

    // Frame monitor for the DIV=2 instance, sampling on the falling edge.
    initial begin
        exp_t        cur;
        logic        in_frame = 1'b0;
        logic        prev_clk = 1'b0;
        logic [15:0] bits = '0;
        int          t0 = 0, nbits = 0, clr_lo = 0, first_clr = 0, en_hi = 0;
        cur = '{ack: 2'b00, owner: 1'b0, bits: 16'h0};
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                in_frame = 1'b0;
                prev_clk = 1'b0;
            end else begin
                if (ack !== 2'b00) begin
                    ack_cnt++;
                    prev_ack_cyc = last_ack_cyc;
                    last_ack_cyc = cyc;
                    check("ack_expected", 32'(sb_q.size() > 0), 32'd1);
                    if (sb_q.size() > 0) begin
                        cur = sb_q.pop_front();
                        check("ack_value", 32'(ack), 32'(cur.ack));
                        check("owner_at_ack", 32'(owner), 32'(cur.owner));
                        check("busy_at_ack", 32'(busy), 32'd1);
                    end
                    in_frame = 1'b1;
                    t0 = cyc; bits = '0; nbits = 0; clr_lo = 0; first_clr = 0; en_hi = 0;
                end else if (in_frame) begin
                    if (!led_clr) begin
                        if (clr_lo == 0) first_clr = cyc - t0;
                        clr_lo++;
                    end
                    if (led_en) en_hi++;
                    if (led_clk && !prev_clk) begin
                        bits = {bits[14:0], led_d0};
                        nbits++;
                    end
                end
                if (done) begin
                    done_cnt++;
                    check("done_in_frame", 32'(in_frame), 32'd1);
                    if (in_frame) begin
                        check("frame_len", 32'(cyc - t0), 32'd72);
                        check("frame_bits", 32'(bits), 32'(cur.bits));
                        check("rise_count", 32'(nbits), 32'd16);
                        check("clr_first", 32'(first_clr), 32'd1);
                        check("clr_len", 32'(clr_lo), 32'd4);
                        check("en_len", 32'(en_hi), 32'd4);
                        check("en_at_done", 32'(led_en), 32'd1);
                        check("busy_at_done", 32'(busy), 32'd1);
                    end
                    in_frame = 1'b0;
                end
                prev_clk = led_clk;
            end
        end
    end

    initial begin
        vec_t vecs[6];
        int   base;
        int   done_base;

        vecs[0] = '{req: 2'b01, d0: 16'hA5C3, d1: 16'h0000, exp_ack: 2'b01};
        vecs[1] = '{req: 2'b10, d0: 16'h0000, d1: 16'h1234, exp_ack: 2'b10};
        vecs[2] = '{req: 2'b11, d0: 16'h0F0F, d1: 16'hF0F0, exp_ack: 2'b01};
        vecs[3] = '{req: 2'b11, d0: 16'h3C3C, d1: 16'h8001, exp_ack: 2'b10};
        vecs[4] = '{req: 2'b10, d0: 16'h0000, d1: 16'hFFFF, exp_ack: 2'b10};
        vecs[5] = '{req: 2'b11, d0: 16'h0001, d1: 16'h7FFE, exp_ack: 2'b01};

        // Reset state.
        step(); step();
        check("rst_led_clk", 32'(led_clk), 32'd0);
        check("rst_led_clr", 32'(led_clr), 32'd1);
        check("rst_led_en",  32'(led_en),  32'd0);
        check("rst_led_d0",  32'(led_d0),  32'd0);
        check("rst_ack",     32'(ack),     32'd0);
        check("rst_done",    32'(done),    32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_owner",   32'(owner),   32'd1);
        check("rst_owner_b", 32'(owner_b), 32'd1);
        rst = 1'b0;
        step();

        // Tie after reset: requester 0 first, then 1 two cycles after done,
        // then 0 again while both keep requesting.
        sb_q.push_back(mk_exp(2'b01, 16'hA5C3, 16'hFFFF));
        sb_q.push_back(mk_exp(2'b10, 16'hA5C3, 16'hFFFF));
        sb_q.push_back(mk_exp(2'b01, 16'hA5C3, 16'hFFFF));
        data0 = 16'hA5C3;
        data1 = 16'hFFFF;
        req   = 2'b11;
        wait_acks("tie_ack1", 1, 20);
        wait_acks("tie_ack2", 2, 200);
        check("tie_gap_1_2", 32'(last_ack_cyc - prev_ack_cyc), 32'd74);
        wait_acks("tie_ack3", 3, 200);
        req = 2'b00;
        check("tie_gap_2_3", 32'(last_ack_cyc - prev_ack_cyc), 32'd74);
        wait_dones("tie_done3", 3, 200);
        step();
        check("idle_after_frame_busy", 32'(busy), 32'd0);

        // Table of single frames, including ties against a known last owner.
        for (int i = 0; i < 6; i++) begin
            sb_q.push_back(mk_exp(vecs[i].exp_ack, vecs[i].d0, vecs[i].d1));
            data0 = vecs[i].d0;
            data1 = vecs[i].d1;
            req   = vecs[i].req;
            wait_acks($sformatf("vec%0d_ack", i), ack_cnt + 1, 20);
            req = 2'b00;
            wait_dones($sformatf("vec%0d_done", i), done_cnt + 1, 200);
        end

        // Withdrawn request: requester 0 raises and drops req while busy.
        sb_q.push_back(mk_exp(2'b10, 16'h0000, 16'h1111));
        data1 = 16'h1111;
        req   = 2'b10;
        wait_acks("wd_ack", ack_cnt + 1, 20);
        req  = 2'b00;
        base = ack_cnt;
        repeat (10) step();
        req = 2'b01;
        step();
        req = 2'b00;
        wait_dones("wd_done", done_cnt + 1, 200);
        repeat (90) step();
        check("wd_no_extra_ack", 32'(ack_cnt), 32'(base));
        check("wd_idle", 32'(busy), 32'd0);

        // Reset at T0+20 aborts the frame with outputs at reset values.
        sb_q.push_back(mk_exp(2'b01, 16'h5A5A, 16'h0000));
        data0 = 16'h5A5A;
        req   = 2'b01;
        wait_acks("abort_ack", ack_cnt + 1, 20);
        req = 2'b00;
        done_base = done_cnt;
        repeat (19) step();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_led_clk", 32'(led_clk), 32'd0);
        check("abort_led_clr", 32'(led_clr), 32'd1);
        check("abort_led_en",  32'(led_en),  32'd0);
        check("abort_led_d0",  32'(led_d0),  32'd0);
        check("abort_ack",     32'(ack),     32'd0);
        check("abort_busy",    32'(busy),    32'd0);
        check("abort_owner",   32'(owner),   32'd1);
        repeat (3) step();
        rst = 1'b0;
        check("abort_no_done", 32'(done_cnt), 32'(done_base));
        sb_q.push_back(mk_exp(2'b10, 16'h0000, 16'h9C31));
        data1 = 16'h9C31;
        req   = 2'b10;
        wait_acks("post_rst_ack", ack_cnt + 1, 20);
        req = 2'b00;
        wait_dones("post_rst_done", done_cnt + 1, 200);
        check("post_rst_one_done", 32'(done_cnt), 32'(done_base + 1));
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        // DIV=1 instance: 36-cycle frame, led_clk rises every other cycle.
        begin
            int          t0b = -1, first_r = -1, last_r = -1, nb = 0, len = -1;
            logic [15:0] bb = '0;
            logic        pc = 1'b0;
            data1_b = 16'hC0A3;
            req_b   = 2'b10;
            for (int i = 0; i < 120 && len < 0; i++) begin
                step();
                if (ack_b != 2'b00 && t0b < 0) begin
                    t0b = i;
                    check("b_ack", 32'(ack_b), 32'h2);
                    check("b_owner", 32'(owner_b), 32'd1);
                    req_b = 2'b00;
                end
                if (t0b >= 0) begin
                    if (led_clk_b && !pc) begin
                        if (first_r < 0) first_r = i;
                        last_r = i;
                        bb = {bb[14:0], led_d0_b};
                        nb++;
                    end
                    if (done_b) len = i - t0b;
                end
                pc = led_clk_b;
            end
            check("b_frame_len", 32'(len), 32'd36);
            check("b_rises", 32'(nb), 32'd16);
            check("b_rise_span", 32'(last_r - first_r), 32'd30);
            check("b_first_rise", 32'(first_r - t0b), 32'd4);
            check("b_bits", 32'(bb), 32'(shown(16'hC0A3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
